// File: rtl/ame_pkg.sv
// Shared state type and matrix geometry for the affine motion estimation
// normal-equation accumulator and its row multiplier.
package ame_pkg;

  localparam int AME_ROWS         = 6;
  localparam int AME_COLS         = 7;
  localparam int AME_ROW_FIRST_4P = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DONE
  } accum_state_t;

  // Column 6 (the B vector) is always live; the 4-parameter model drops columns 0..1.
  function automatic logic [AME_COLS-1:0] col_mask(input logic p6);
    return p6 ? 7'b111_1111 : 7'b111_1100;
  endfunction

endpackage

// File: rtl/ame_row_mac.sv
// Combinational row multiplier: forms c[row]*c[j] for the six A columns and
// c[row]*r for the B column, sign-extended to the accumulator width.
module ame_row_mac
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int COEF_BITS      = 24
) (
  input  logic [AME_ROWS-1:0][COEF_BITS-1:0]      coef_i,
  input  logic [COEF_BITS-1:0]                    res_i,
  input  logic [2:0]                              row_i,
  input  logic [AME_COLS-1:0]                     col_mask_i,
  output logic [AME_COLS-1:0][COMP_DATA_BITS-1:0] prod_o
);

  function automatic logic [COMP_DATA_BITS-1:0] sext_mul(
    input logic signed [COEF_BITS-1:0] a,
    input logic signed [COEF_BITS-1:0] b
  );
    logic signed [2*COEF_BITS-1:0] p;
    p = a * b;
    return COMP_DATA_BITS'(p);
  endfunction

  logic [COEF_BITS-1:0] row_coef;

  always_comb begin
    row_coef = coef_i[row_i];
    prod_o   = '0;
    for (int j = 0; j < AME_ROWS; j++) begin
      if (col_mask_i[j]) begin
        prod_o[j] = sext_mul(row_coef, coef_i[j]);
      end
    end
    if (col_mask_i[AME_COLS-1]) begin
      prod_o[AME_COLS-1] = sext_mul(row_coef, res_i);
    end
  end

endmodule

// File: rtl/ame_matrix_accum.sv
// Accumulates the 6x7 affine motion normal-equation system, one matrix row
// per cycle, from a stream of gradient coefficient vectors and residuals.
module ame_matrix_accum
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = 64,
  parameter int COEF_BITS      = 24
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic                                        affine_param6_i,
  input  logic                                        comp_init_i,
  output logic                                        comp_done_o,
  input  logic                                        smp_valid_i,
  output logic                                        smp_ready_o,
  input  logic                                        smp_last_i,
  input  logic [5:0][COEF_BITS-1:0]                   smp_coef_i,
  input  logic [COEF_BITS-1:0]                        smp_res_i,
  output logic [5:0][6:0][COMP_DATA_BITS-1:0]         comp_data_o
);

  typedef logic [AME_ROWS-1:0][AME_COLS-1:0][COMP_DATA_BITS-1:0] acc_t;

  accum_state_t                      state_q, state_d;
  acc_t                              acc_q, acc_d;
  logic [AME_ROWS-1:0][COEF_BITS-1:0] coef_q, coef_d;
  logic [COEF_BITS-1:0]              res_q, res_d;
  logic                              last_q, last_d;
  logic                              p6_q, p6_d;
  logic                              ready_q, ready_d;
  logic                              done_q, done_d;
  logic [2:0]                        row_q, row_d;
  logic [AME_COLS-1:0][COMP_DATA_BITS-1:0] prod;

  ame_row_mac #(
    .COMP_DATA_BITS(COMP_DATA_BITS),
    .COEF_BITS     (COEF_BITS)
  ) u_row_mac (
    .coef_i    (coef_q),
    .res_i     (res_q),
    .row_i     (row_q),
    .col_mask_i(col_mask(p6_q)),
    .prod_o    (prod)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    coef_d  = coef_q;
    res_d   = res_q;
    last_d  = last_q;
    p6_d    = p6_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (comp_init_i) begin
          acc_d   = '0;
          p6_d    = affine_param6_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (smp_valid_i && ready_q) begin
          coef_d  = smp_coef_i;
          res_d   = smp_res_i;
          last_d  = smp_last_i;
          row_d   = p6_q ? 3'd0 : 3'(AME_ROW_FIRST_4P);
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        // Masked columns contribute zero, so the whole row can be updated uniformly.
        for (int j = 0; j < AME_COLS; j++) begin
          acc_d[row_q][j] = acc_q[row_q][j] + prod[j];
        end
        if (row_q == 3'(AME_ROWS-1)) begin
          state_d = last_q ? ST_DONE : ST_LOAD;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_LOAD);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      coef_q  <= '0;
      res_q   <= '0;
      last_q  <= 1'b0;
      p6_q    <= 1'b0;
      row_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      coef_q  <= coef_d;
      res_q   <= res_d;
      last_q  <= last_d;
      p6_q    <= p6_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign smp_ready_o = ready_q;
  assign comp_done_o = done_q;
  assign comp_data_o = acc_q;

endmodule

// File: tb/tb_ame_matrix_accum.sv
// Self-checking bench for ame_matrix_accum: table vectors, control corner
// sequences and randomized blocks against a sum-of-products reference model.
module tb_ame_matrix_accum;

  localparam int CB = 24;
  localparam int DB = 64;
  localparam int NB = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n, p6, init, valid, last;
  logic [5:0][CB-1:0]        coef;
  logic [CB-1:0]             res;
  logic                      done, ready, done_w, ready_w;
  logic [5:0][6:0][DB-1:0]   data;
  logic [5:0][6:0][NB-1:0]   data_w;

  ame_matrix_accum #(.COMP_DATA_BITS(DB), .COEF_BITS(CB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .affine_param6_i(p6), .comp_init_i(init),
    .comp_done_o(done), .smp_valid_i(valid), .smp_ready_o(ready),
    .smp_last_i(last), .smp_coef_i(coef), .smp_res_i(res), .comp_data_o(data)
  );

  // Narrow accumulator copy, sharing all inputs, makes wrap-around reachable quickly.
  ame_matrix_accum #(.COMP_DATA_BITS(NB), .COEF_BITS(CB)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .affine_param6_i(p6), .comp_init_i(init),
    .comp_done_o(done_w), .smp_valid_i(valid), .smp_ready_o(ready_w),
    .smp_last_i(last), .smp_coef_i(coef), .smp_res_i(res), .comp_data_o(data_w)
  );

  int     checks = 0;
  int     errors = 0;
  longint model [6][7];
  bit     model_p6;

  typedef struct {
    bit                 p6;
    logic [5:0][CB-1:0] c;
    logic [CB-1:0]      r;
    int                 n;
    int                 lat;
    logic [2:0][2:0]    sr;
    logic [2:0][2:0]    sc;
    logic [2:0][63:0]   sv;
  } vec_t;

  vec_t vecs [4];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic abortRun(input string name);
    errors++;
    $display("[TB] FAIL %s: timed out", name);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] aborted");
  endtask

  function automatic longint sx(input logic [CB-1:0] v);
    return longint'(signed'(v));
  endfunction

  task automatic modelInit(input bit m);
    model_p6 = m;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        model[i][j] = 0;
  endtask

  // A += c*c^T and B += c*r over the active parameter set.
  task automatic modelAdd(input logic [5:0][CB-1:0] c, input logic [CB-1:0] r);
    longint v;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        if (model_p6 || (i >= 2 && j >= 2)) begin
          if (j == 6) v = sx(r);
          else        v = sx(c[j]);
          model[i][j] += sx(c[i]) * v;
        end
  endtask

  task automatic compareMatrix(input string tag);
    logic [NB-1:0] t;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++) begin
        checkOutput($sformatf("%s m[%0d][%0d]", tag, i, j), longint'(data[i][j]), model[i][j]);
        t = NB'(model[i][j]);
        checkOutput($sformatf("%s narrow m[%0d][%0d]", tag, i, j),
                    longint'(signed'(data_w[i][j])), longint'(signed'(t)));
      end
  endtask

  task automatic startBlock(input bit m);
    @(negedge clk);
    p6   = m;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    p6   = ~m;
    modelInit(m);
    checkOutput("ready after init", longint'(ready), 1);
  endtask

  // Present one sample after 'gap' idle cycles; returns on the negedge after acceptance.
  task automatic applyStimulus(input logic [5:0][CB-1:0] c, input logic [CB-1:0] r,
                               input bit l, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    coef  = c;
    res   = r;
    last  = l;
    valid = 1'b1;
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready) abortRun("sample accept");
    @(negedge clk);
    valid = 1'b0;
    modelAdd(c, r);
  endtask

  task automatic waitDone(input int lat, input bit pulse, input string tag);
    int k;
    k = 1;
    while (!done && k < 40) begin
      if (pulse && k == 2) init = 1'b1;
      if (pulse && k == 3) init = 1'b0;
      @(negedge clk);
      k++;
    end
    init = 1'b0;
    if (!done) abortRun({tag, " done"});
    checkOutput({tag, " done latency"}, longint'(k), longint'(lat));
    compareMatrix(tag);
    if (pulse) init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    checkOutput({tag, " done one cycle"}, longint'(done), 0);
    if (pulse) begin
      @(negedge clk);
      checkOutput({tag, " init in DONE ignored"}, longint'(ready), 0);
      compareMatrix({tag, " held"});
    end
  endtask

  task automatic runBlock(input bit m, input logic [5:0][CB-1:0] c, input logic [CB-1:0] r,
                          input int n, input int lat, input bit pulse, input string tag);
    startBlock(m);
    for (int s = 0; s < n; s++) applyStimulus(c, r, (s == n - 1), 0);
    waitDone(lat, pulse, tag);
  endtask

  initial begin
    #2_000_000;
    abortRun("global watchdog");
  end

  initial begin
    logic [5:0][CB-1:0] cv;
    logic [CB-1:0]      rv;
    int                 hi_cnt, last_hi, n, gap;
    bit                 m;
    longint             nz;

    rst_n = 1'b0; p6 = 1'b0; init = 1'b0; valid = 1'b0; last = 1'b0;
    coef = '0; res = '0;

    vecs[0] = '{1'b1, {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1}, 24'd7, 1, 7,
                {3'd0, 3'd5, 3'd2}, {3'd0, 3'd6, 3'd4}, {64'd1, 64'd42, 64'd15}};
    vecs[1] = '{1'b0, {-24'sd5, 24'd4, -24'sd3, 24'd2, 24'd9, 24'd9}, 24'hFFFFFF, 2, 5,
                {3'd1, 3'd2, 3'd3}, {3'd3, 3'd6, 3'd5}, {64'd0, -64'sd4, 64'd30}};
    vecs[2] = '{1'b1, {6{24'h800000}}, 24'h7FFFFF, 1024, 7,
                {3'd5, 3'd4, 3'd0}, {3'd2, 3'd6, 3'd0},
                {64'd1 << 56, -(64'd1 << 56) + (64'd1 << 33), 64'd1 << 56}};
    vecs[3] = '{1'b0, {6{24'h7FFFFF}}, 24'h800000, 3, 5,
                {3'd1, 3'd2, 3'd5}, {3'd1, 3'd6, 3'd5},
                {64'd0, -64'sd3 * ((64'd1 << 46) - (64'd1 << 23)),
                 64'd3 * ((64'd1 << 46) - (64'd1 << 24) + 64'd1)}};

    repeat (3) @(negedge clk);
    checkOutput("reset ready", longint'(ready), 0);
    checkOutput("reset done", longint'(done), 0);
    checkOutput("reset data", longint'(|data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      runBlock(vecs[v].p6, vecs[v].c, vecs[v].r, vecs[v].n, vecs[v].lat, 1'b0,
               $sformatf("vec%0d", v));
      for (int s = 0; s < 3; s++)
        checkOutput($sformatf("vec%0d spot%0d", v, s),
                    longint'(data[vecs[v].sr[s]][vecs[v].sc[s]]), longint'(vecs[v].sv[s]));
    end

    // Wrap-around on the narrow copy: 2^46 per sample, 50-bit accumulator.
    cv = '0;
    cv[0] = 24'h800000;
    for (int q = 0; q < 3; q++) begin
      n = 4 << q;
      runBlock(1'b1, cv, 24'd0, n, 7, 1'b0, $sformatf("ovf%0d", n));
      checkOutput($sformatf("ovf%0d wide A00", n), longint'(data[0][0]), longint'(n) <<< 46);
      checkOutput($sformatf("ovf%0d narrow A00", n), longint'(signed'(data_w[0][0])),
                  (q == 0) ? (64'sd1 <<< 48) : (q == 1) ? -(64'sd1 <<< 49) : 64'sd0);
    end

    // Init and sample together in IDLE: only the later sample may be accepted.
    @(negedge clk);
    p6 = 1'b1; init = 1'b1; valid = 1'b1; last = 1'b1;
    coef = {6{24'd5}}; res = 24'd3;
    @(negedge clk);
    init = 1'b0;
    modelInit(1'b1);
    checkOutput("init+valid ready", longint'(ready), 1);
    cv = {24'd1, 24'd0, -24'sd2, 24'd0, 24'd3, 24'd0};
    coef = cv; res = 24'd11;
    @(negedge clk);
    valid = 1'b0;
    modelAdd(cv, 24'd11);
    waitDone(7, 1'b0, "init+valid");

    // Backpressure: valid held high, one acceptance per LOAD visit.
    startBlock(1'b1);
    cv = {24'd3, -24'sd1, 24'd2, 24'd7, -24'sd4, 24'd1};
    coef = cv; res = 24'd9; last = 1'b0; valid = 1'b1;
    hi_cnt = 0; last_hi = -1;
    for (int k = 0; k < 35; k++) begin
      if (k > 0) @(negedge clk);
      if (ready) begin
        if (last_hi >= 0) checkOutput("ready period", longint'(k - last_hi), 7);
        last_hi = k;
        hi_cnt++;
        modelAdd(cv, 24'd9);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    checkOutput("backpressure accepts", longint'(hi_cnt), 5);
    applyStimulus({24'd1, 24'd1, 24'd1, 24'd1, 24'd1, 24'd1}, 24'd2, 1'b1, 0);
    waitDone(7, 1'b0, "backpressure");

    // Init pulses during MAC and DONE are ignored.
    runBlock(1'b1, vecs[0].c, vecs[0].r, 2, 7, 1'b1, "init ignore p6");
    runBlock(1'b0, vecs[1].c, vecs[1].r, 1, 5, 1'b1, "init ignore p4");

    // Asynchronous reset mid-MAC, then a clean block.
    startBlock(1'b1);
    applyStimulus(vecs[0].c, vecs[0].r, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nz = longint'(|data) + longint'(|data_w);
    checkOutput("mid-MAC reset data", nz, 0);
    checkOutput("mid-MAC reset ready", longint'(ready), 0);
    checkOutput("mid-MAC reset done", longint'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle after reset", longint'(ready), 0);
    valid = 1'b0;
    runBlock(1'b1, vecs[0].c, vecs[0].r, 1, 7, 1'b0, "after reset");

    // Randomized blocks against the reference model.
    for (int b = 0; b < 16; b++) begin
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      startBlock(m);
      for (int s = 0; s < n; s++) begin
        for (int k = 0; k < 6; k++)
          cv[k] = ($urandom_range(0, 3) == 0) ? 24'h800000 : CB'($urandom);
        rv  = CB'($urandom);
        gap = $urandom_range(0, 3);
        applyStimulus(cv, rv, (s == n - 1), gap);
      end
      waitDone(m ? 7 : 5, 1'b0, $sformatf("rand%0d", b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
